half_adder_checker: RTL and testbench
=====================================

Name: half_adder_checker

Overview:
On-FPGA self-test engine for the half adder; it is the hardware counterpart of the simulation bench. It drives all four a/b input combinations into a HalfAdder instance, waits a programmable settle time, and checks sum/carry against expected values. It counts mismatches and reports pass/fail on board-visible outputs such as LEDs.

Parameters:
SETTLE_CYCLES, 2, cycles each vector is held before sampling; legal range >= 1
PASSES, 1, number of full 4-vector sweeps per run; legal range >= 1
ERR_W, 8, width of the mismatch counter

Ports:
clk_in  input  1  system clock, all logic on rising edge
rst_in  input  1  asynchronous, active-high reset
start_in  input  1  single-cycle run request; sampled in IDLE or DONE only
a_out  output  1  DUT a_in drive, equals vec[1]
b_out  output  1  DUT b_in drive, equals vec[0]
sum_in  input  1  DUT sum_out
carry_in  input  1  DUT carry_out
busy_out  output  1  high in SETTLE and CHECK
done_out  output  1  high in DONE, held until the next start
pass_out  output  1  valid when done_out=1; 1 iff err_cnt_out==0
err_cnt_out  output  ERR_W  saturating mismatch count for the current run
vec_out  output  2  current vector index {a,b}
fail_vec_out  output  2  first failing vector (optional feature)
fail_obs_out  output  2  {carry_in,sum_in} observed at first failure (optional feature)

Behaviour:
- Reset, asynchronous, any state: state=IDLE, vec=0, settle counter=0, pass counter=0, err_cnt=0. All outputs are 0.
- State machine: IDLE, SETTLE, CHECK, DONE. The state register, vec, counters and err_cnt are registered. a_out, b_out and vec_out are decoded from the vec register.
- IDLE or DONE with start_in=1: clear err_cnt, clear pass counter, clear the optional capture. Set vec=0, load settle counter with SETTLE_CYCLES-1, go to SETTLE.
- start_in in SETTLE or CHECK: ignored; there is no restart and no error.
- SETTLE: decrement the counter each cycle. When the counter is 0, go to CHECK. The vector is held for exactly SETTLE_CYCLES cycles.
- CHECK (one cycle):
  - Expected values: sum=a^b, carry=a&b.
  - Mismatch on either output: err_cnt increments once per vector, saturating at 2^ERR_W-1.
  - Transitions:
    - vec!=3: vec=vec+1, reload counter, go to SETTLE.
    - vec==3 and pass counter!=PASSES-1: vec wraps to 0, pass counter increments, go to SETTLE.
    - Otherwise: go to DONE.
- DONE: done_out=1 and pass_out=(err_cnt==0). vec holds at 3. err_cnt holds.
- Latency: start sampled at edge k gives done_out=1 after edge k+PASSES*4*(SETTLE_CYCLES+1).
- Outside DONE: done_out=0 and pass_out=0.
- Reset mid-run: the run is aborted, returns to IDLE with all outputs 0, and err_cnt is lost.
- sum_in and carry_in are sampled only in CHECK. Their values in other states have no effect.

Optional Feature:
HA_CHECK_FIRST_FAIL_EN
- Defined: on the first mismatching CHECK of a run, capture fail_vec_out=vec and fail_obs_out={carry_in,sum_in}. Later mismatches do not overwrite the capture. The capture is cleared to 0 by reset and by start.
- Undefined: the capture registers are not built, and fail_vec_out and fail_obs_out are tied to 0. All other behaviour is identical.

Test Plan:
- Correct HalfAdder attached, defaults, start pulse: vec_out steps 0,1,2,3 with 3 cycles each. done_out=1 exactly 12 cycles after start. pass_out=1, err_cnt_out=0.
- sum_in forced 0: err_cnt_out=2 (vectors 01,10) and pass_out=0. With HA_CHECK_FIRST_FAIL_EN: fail_vec_out=01, fail_obs_out=00.
- carry_in forced 1, PASSES=2: err_cnt_out=6 (vectors 00,01,10 per pass). done_out after 24 cycles.
- ERR_W=2, carry_in forced 1, PASSES=2: err_cnt_out saturates at 3. pass_out=0.
- start_in pulsed during SETTLE of vec 2: no restart, same done timing as an undisturbed run. start_in in DONE: new run begins and err_cnt_out clears to 0.
- rst_in asserted asynchronously mid-CHECK: all outputs 0 immediately. After release, no activity until the next start.

Source files
------------

// File: rtl/half_adder_checker.sv
// -----------------------------------------------------------------------------
// half_adder_checker
//
// On-board self-test engine for a half adder. Sweeps the four {a,b} input
// combinations into an attached half adder, holds each vector for SETTLE_CYCLES
// cycles, then spends one CHECK cycle comparing sum/carry against a^b / a&b.
// Mismatching vectors are counted in a saturating counter. When all PASSES
// sweeps are finished the engine sits in DONE with pass/fail visible.
//
// Optional feature macro: HA_CHECK_FIRST_FAIL_EN
//   defined   -> capture vector and observed {carry,sum} of the first failure
//   undefined -> fail_vec_out / fail_obs_out tied to 0, no capture registers
//
// Ports:
//   clk_in        system clock, rising edge
//   rst_in        asynchronous active-high reset
//   start_in      single-cycle run request, honoured only in IDLE or DONE
//   a_out, b_out  drive to the half adder under test (vec[1], vec[0])
//   sum_in        half adder sum output
//   carry_in      half adder carry output
//   busy_out      high in SETTLE and CHECK
//   done_out      high in DONE, held until the next start
//   pass_out      high in DONE when no mismatch was seen
//   err_cnt_out   saturating mismatch count for the current run
//   vec_out       current vector index {a,b}
//   fail_vec_out  first failing vector (optional feature, else 0)
//   fail_obs_out  {carry_in,sum_in} seen at first failure (optional, else 0)
//   state_out     FSM state for debug (0 IDLE, 1 SETTLE, 2 CHECK, 3 DONE)
//
// Handshake: start_in is a plain one-cycle request with no ready/ack; a pulse
// while busy is dropped, and completion is signalled by done_out level.
// -----------------------------------------------------------------------------
module half_adder_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 1,
    parameter int ERR_W         = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    output logic             a_out,
    output logic             b_out,
    input  logic             sum_in,
    input  logic             carry_in,
    output logic             busy_out,
    output logic             done_out,
    output logic             pass_out,
    output logic [ERR_W-1:0] err_cnt_out,
    output logic [1:0]       vec_out,
    output logic [1:0]       fail_vec_out,
    output logic [1:0]       fail_obs_out,
    output logic [1:0]       state_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Counters hold values up to N-1, so $clog2(N) bits suffice; keep >= 1 bit.
    localparam int CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [PASS_W-1:0] PASS_LAST   = PASS_W'(PASSES - 1);

    state_t              state;
    logic [1:0]          vec;
    logic [CNT_W-1:0]    settle_cnt;
    logic [PASS_W-1:0]   pass_cnt;
    logic [ERR_W-1:0]    err_cnt;

    logic exp_sum;
    logic exp_carry;
    logic mismatch;
    logic start_ok;

    assign exp_sum   = vec[1] ^ vec[0];
    assign exp_carry = vec[1] & vec[0];
    assign mismatch  = (sum_in != exp_sum) || (carry_in != exp_carry);
    assign start_ok  = start_in && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state      <= IDLE;
            vec        <= 2'd0;
            settle_cnt <= '0;
            pass_cnt   <= '0;
            err_cnt    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_in) begin
                        err_cnt    <= '0;
                        pass_cnt   <= '0;
                        vec        <= 2'd0;
                        settle_cnt <= SETTLE_LOAD;
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                CHECK: begin
                    // One increment per failing vector, sticking at all-ones.
                    if (mismatch && (err_cnt != '1)) begin
                        err_cnt <= err_cnt + 1'b1;
                    end
                    if (vec != 2'd3) begin
                        vec        <= vec + 2'd1;
                        settle_cnt <= SETTLE_LOAD;
                        state      <= SETTLE;
                    end else if (pass_cnt != PASS_LAST) begin
                        vec        <= 2'd0;
                        pass_cnt   <= pass_cnt + 1'b1;
                        settle_cnt <= SETTLE_LOAD;
                        state      <= SETTLE;
                    end else begin
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef HA_CHECK_FIRST_FAIL_EN
    logic [1:0] fail_vec;
    logic [1:0] fail_obs;

    // err_cnt saturates instead of wrapping, so err_cnt==0 during CHECK means
    // this is the first mismatch of the run.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            fail_vec <= 2'd0;
            fail_obs <= 2'd0;
        end else if (start_ok) begin
            fail_vec <= 2'd0;
            fail_obs <= 2'd0;
        end else if ((state == CHECK) && mismatch && (err_cnt == '0)) begin
            fail_vec <= vec;
            fail_obs <= {carry_in, sum_in};
        end
    end

    assign fail_vec_out = fail_vec;
    assign fail_obs_out = fail_obs;
`else
    assign fail_vec_out = 2'd0;
    assign fail_obs_out = 2'd0;
`endif

    assign a_out       = vec[1];
    assign b_out       = vec[0];
    assign vec_out     = vec;
    assign busy_out    = (state == SETTLE) || (state == CHECK);
    assign done_out    = (state == DONE);
    assign pass_out    = (state == DONE) && (err_cnt == '0);
    assign err_cnt_out = err_cnt;
    assign state_out   = state;

endmodule

// File: tb/tb_half_adder_checker.sv
// -----------------------------------------------------------------------------
// Bench for half_adder_checker. Three instances share clock/reset/start:
//   u0: defaults (SETTLE_CYCLES=2, PASSES=1, ERR_W=8)
//   u1: PASSES=2 (ERR_W=8)
//   u2: PASSES=2, ERR_W=2, SETTLE_CYCLES=1 (saturation, minimum settle)
// A behavioural half adder with selectable stuck-at faults feeds each one.
// -----------------------------------------------------------------------------
module tb_half_adder_checker;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    logic start;
    int   mode;   // 0 good, 1 sum stuck 0, 2 carry stuck 1, 3 sum stuck 1

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

`ifdef HA_CHECK_FIRST_FAIL_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    // ---------------- DUT wiring ----------------
    logic a0, b0, s0, c0, busy0, done0, pass0;
    logic [7:0] err0;
    logic [1:0] vec0, fv0, fo0, st0;
    logic a1, b1, s1, c1, busy1, done1, pass1;
    logic [7:0] err1;
    logic [1:0] vec1, fv1, fo1, st1;
    logic a2, b2, s2, c2, busy2, done2, pass2;
    logic [1:0] err2;
    logic [1:0] vec2, fv2, fo2, st2;

    function automatic logic ha_sum(input logic a, input logic b, input int m);
        if (m == 1) return 1'b0;
        if (m == 3) return 1'b1;
        return a ^ b;
    endfunction

    function automatic logic ha_carry(input logic a, input logic b, input int m);
        if (m == 2) return 1'b1;
        return a & b;
    endfunction

    assign s0 = ha_sum(a0, b0, mode);
    assign c0 = ha_carry(a0, b0, mode);
    assign s1 = ha_sum(a1, b1, mode);
    assign c1 = ha_carry(a1, b1, mode);
    assign s2 = ha_sum(a2, b2, mode);
    assign c2 = ha_carry(a2, b2, mode);

    half_adder_checker u0 (
        .clk_in(clk), .rst_in(rst), .start_in(start),
        .a_out(a0), .b_out(b0), .sum_in(s0), .carry_in(c0),
        .busy_out(busy0), .done_out(done0), .pass_out(pass0),
        .err_cnt_out(err0), .vec_out(vec0),
        .fail_vec_out(fv0), .fail_obs_out(fo0), .state_out(st0)
    );

    half_adder_checker #(.SETTLE_CYCLES(2), .PASSES(2), .ERR_W(8)) u1 (
        .clk_in(clk), .rst_in(rst), .start_in(start),
        .a_out(a1), .b_out(b1), .sum_in(s1), .carry_in(c1),
        .busy_out(busy1), .done_out(done1), .pass_out(pass1),
        .err_cnt_out(err1), .vec_out(vec1),
        .fail_vec_out(fv1), .fail_obs_out(fo1), .state_out(st1)
    );

    half_adder_checker #(.SETTLE_CYCLES(1), .PASSES(2), .ERR_W(2)) u2 (
        .clk_in(clk), .rst_in(rst), .start_in(start),
        .a_out(a2), .b_out(b2), .sum_in(s2), .carry_in(c2),
        .busy_out(busy2), .done_out(done2), .pass_out(pass2),
        .err_cnt_out(err2), .vec_out(vec2),
        .fail_vec_out(fv2), .fail_obs_out(fo2), .state_out(st2)
    );

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [7:0] err;
        logic       pass;
        logic [1:0] fv;
        logic [1:0] fo;
        logic [7:0] lat;
    } exp_t;

    exp_t exp0_q[$];
    exp_t exp1_q[$];
    exp_t exp2_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " u0 outputs zero"},
              {a0, b0, busy0, done0, pass0, err0, vec0, fv0, fo0, st0}, 0);
        check({tag, " u1 outputs zero"},
              {a1, b1, busy1, done1, pass1, err1, vec1, fv1, fo1, st1}, 0);
        check({tag, " u2 outputs zero"},
              {a2, b2, busy2, done2, pass2, err2, vec2, fv2, fo2, st2}, 0);
    endtask

    task automatic compare_done(input string tag, input exp_t e, input int lat,
                                input logic [7:0] err, input logic pass,
                                input logic [1:0] fv, input logic [1:0] fo);
        check({tag, " latency"}, lat, e.lat);
        check({tag, " err_cnt"}, err, e.err);
        check({tag, " pass"}, pass, e.pass);
        check({tag, " fail_vec"}, fv, e.fv);
        check({tag, " fail_obs"}, fo, e.fo);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int         mode;
        int         err0;
        int         err1;
        int         err2;
        logic       pass;
        logic [1:0] fvec;
        logic [1:0] fobs;
        int         glitch;   // cycle index at which to pulse start mid-run, -1 none
    } row_t;

    row_t rows[5];

    // Drive one run from IDLE/DONE and follow all three instances to DONE.
    task automatic run_row(input int idx, input row_t r);
        exp_t e;
        logic [2:0] seen;
        logic [1:0] ev;
        string tag;
        tag = $sformatf("row%0d", idx);
        mode = r.mode;
        e.pass = r.pass;
        e.fv   = CAP ? r.fvec : 2'd0;
        e.fo   = CAP ? r.fobs : 2'd0;
        e.err = 8'(r.err0); e.lat = 8'd12; exp0_q.push_back(e);
        e.err = 8'(r.err1); e.lat = 8'd24; exp1_q.push_back(e);
        e.err = 8'(r.err2); e.lat = 8'd16; exp2_q.push_back(e);

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Now just after the edge that accepted start (cycle index 0).
        check({tag, " err cleared on start"}, err0, 0);
        check({tag, " capture cleared on start"}, {fv0, fo0}, 0);
        seen = 3'b000;
        for (int j = 0; j < 64 && seen != 3'b111; j++) begin
            if (j < 12) begin
                ev = 2'(j / 3);
                check({tag, " u0 vec step"}, vec0, ev);
                check({tag, " u0 a/b drive"}, {a0, b0}, ev);
                check({tag, " u0 busy"}, busy0, 1);
            end
            if (!seen[0] && done0) begin
                seen[0] = 1'b1;
                compare_done({tag, " u0"}, exp0_q.pop_front(), j, err0, pass0, fv0, fo0);
                check({tag, " u0 vec held 3"}, vec0, 3);
                check({tag, " u0 busy low in done"}, busy0, 0);
            end
            if (!seen[1] && done1) begin
                seen[1] = 1'b1;
                compare_done({tag, " u1"}, exp1_q.pop_front(), j, err1, pass1, fv1, fo1);
            end
            if (!seen[2] && done2) begin
                seen[2] = 1'b1;
                compare_done({tag, " u2"}, exp2_q.pop_front(), j, {6'd0, err2}, pass2, fv2, fo2);
            end
            start = (j == r.glitch);
            @(negedge clk);
        end
        start = 1'b0;
        if (!seen[0]) begin check({tag, " u0 done timeout"}, 0, 1); void'(exp0_q.pop_front()); end
        if (!seen[1]) begin check({tag, " u1 done timeout"}, 0, 1); void'(exp1_q.pop_front()); end
        if (!seen[2]) begin check({tag, " u2 done timeout"}, 0, 1); void'(exp2_q.pop_front()); end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        //              mode err0 err1 err2 pass fvec   fobs  glitch
        rows[0] = '{2,  3,   6,   3,   1'b0, 2'b00, 2'b10, -1};
        rows[1] = '{1,  2,   4,   3,   1'b0, 2'b01, 2'b00, -1};
        rows[2] = '{3,  2,   4,   3,   1'b0, 2'b00, 2'b01, -1};
        rows[3] = '{0,  0,   0,   0,   1'b1, 2'b00, 2'b00, -1};
        rows[4] = '{0,  0,   0,   0,   1'b1, 2'b00, 2'b00,  6};

        rst   = 1'b1;
        start = 1'b0;
        mode  = 0;
        #3;
        check_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("idle after reset");

        for (int i = 0; i < 5; i++) begin
            run_row(i, rows[i]);
        end

        // Asynchronous reset in the middle of a CHECK cycle.
        mode = 1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("midrun u0 in CHECK", st0, 2);
        check("midrun u0 err before reset", err0, 1);
        #1 rst = 1'b1;
        #1 check_zero("async reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check_zero("quiet after reset");

        // A normal run still works after the abort.
        run_row(5, rows[3]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute guard against a hang.
    initial begin
        #200000;
        $display("FAIL global timeout: got %0d expected %0d", 0, 1);
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule
